// File: rtl/lcd_write_ctrl.sv
// HD44780-style LCD write sequencer: one byte per handshake with setup, EN pulse, hold and execution wait.
// Optional macro LCD_INIT_EN adds a power-up delay followed by a fixed init command sequence.
module lcd_write_ctrl #(
  parameter int T_AS_CYC    = 3,
  parameter int T_PW_CYC    = 25,
  parameter int T_H_CYC     = 3,
  parameter int T_EXEC_CYC  = 2000,
  parameter int T_CLR_CYC   = 82000,
  parameter int T_PWRUP_CYC = 750000
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_rs_i,
  input  logic [7:0]  req_data_i,
  input  logic        lcd_on_i,
  output logic        busy_o,
  output logic [11:0] io_lcd_o
);

  localparam int MAX_0   = (T_AS_CYC > T_PW_CYC) ? T_AS_CYC : T_PW_CYC;
  localparam int MAX_1   = (MAX_0 > T_H_CYC) ? MAX_0 : T_H_CYC;
  localparam int MAX_2   = (MAX_1 > T_EXEC_CYC) ? MAX_1 : T_EXEC_CYC;
  localparam int MAX_3   = (MAX_2 > T_CLR_CYC) ? MAX_2 : T_CLR_CYC;
  localparam int MAX_CYC = (MAX_3 > T_PWRUP_CYC) ? MAX_3 : T_PWRUP_CYC;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);

  localparam logic [CNT_W-1:0] AS_LOAD    = CNT_W'(T_AS_CYC - 1);
  localparam logic [CNT_W-1:0] PW_LOAD    = CNT_W'(T_PW_CYC - 1);
  localparam logic [CNT_W-1:0] H_LOAD     = CNT_W'(T_H_CYC - 1);
  localparam logic [CNT_W-1:0] EXEC_LOAD  = CNT_W'(T_EXEC_CYC - 1);
  localparam logic [CNT_W-1:0] CLR_LOAD   = CNT_W'(T_CLR_CYC - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_PULSE, S_HOLD, S_WAIT, S_PWRUP
  } state_t;

  // state_q is the observable FSM state for debug and assertion binding.
  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             on_q, en_q, rs_q, ready_q, busy_q;
  logic [7:0]       db_q;
  logic             is_clr;

`ifdef LCD_INIT_EN
  localparam logic [CNT_W-1:0] PWRUP_LOAD = CNT_W'(T_PWRUP_CYC - 1);
  localparam state_t           RST_STATE  = S_PWRUP;
  localparam logic [CNT_W-1:0] RST_CNT    = PWRUP_LOAD;

  logic       init_q;
  logic [2:0] init_idx_q;

  function automatic logic [7:0] init_cmd(input logic [2:0] idx);
    case (idx)
      3'd0, 3'd1: init_cmd = 8'h38;
      3'd2:       init_cmd = 8'h0C;
      3'd3:       init_cmd = 8'h01;
      default:    init_cmd = 8'h06;
    endcase
  endfunction
`else
  localparam state_t           RST_STATE  = S_IDLE;
  localparam logic [CNT_W-1:0] RST_CNT    = '0;
`endif

  // Clear Display (01) and Return Home (02/03) are the slow commands; data bytes never are.
  assign is_clr = !rs_q && (db_q == 8'h01 || db_q == 8'h02 || db_q == 8'h03);

  // Handshake: a request is taken at a rising clk_i edge when req_valid_i and
  // req_ready_o are both high; ready is registered and drops at that same edge.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= RST_STATE;
      cnt_q   <= RST_CNT;
      on_q    <= 1'b0;
      en_q    <= 1'b0;
      rs_q    <= 1'b0;
      db_q    <= 8'h00;
      ready_q <= 1'b0;
      busy_q  <= 1'b1;
`ifdef LCD_INIT_EN
      init_q     <= 1'b1;
      init_idx_q <= 3'd0;
`endif
    end else begin
      on_q <= lcd_on_i;
      case (state_q)
        S_IDLE: begin
          if (req_valid_i && ready_q) begin
            rs_q    <= req_rs_i;
            db_q    <= req_data_i;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_SETUP;
            cnt_q   <= AS_LOAD;
          end else begin
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        S_SETUP: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b1;
            state_q <= S_PULSE;
            cnt_q   <= PW_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_PULSE: begin
          if (cnt_q == '0) begin
            en_q    <= 1'b0;
            state_q <= S_HOLD;
            cnt_q   <= H_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_HOLD: begin
          if (cnt_q == '0) begin
            state_q <= S_WAIT;
            cnt_q   <= is_clr ? CLR_LOAD : EXEC_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
`ifdef LCD_INIT_EN
            if (init_q && init_idx_q != 3'd4) begin
              init_idx_q <= init_idx_q + 3'd1;
              rs_q       <= 1'b0;
              db_q       <= init_cmd(init_idx_q + 3'd1);
              state_q    <= S_SETUP;
              cnt_q      <= AS_LOAD;
            end else begin
              init_q  <= 1'b0;
              ready_q <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= S_IDLE;
            end
`else
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
`endif
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`ifdef LCD_INIT_EN
        S_PWRUP: begin
          if (cnt_q == '0) begin
            rs_q    <= 1'b0;
            db_q    <= init_cmd(3'd0);
            state_q <= S_SETUP;
            cnt_q   <= AS_LOAD;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
`endif
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign req_ready_o = ready_q;
  assign busy_o      = busy_q;
  assign io_lcd_o    = {on_q, en_q, rs_q, 1'b0, db_q};

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Bench for lcd_write_ctrl: cycle-level transaction model plus directed latency/pulse measurements.
// Compile with +define+LCD_INIT_EN to exercise the power-up init sequence.
module tb_lcd_write_ctrl;

  localparam int T_AS = 2, T_PW = 4, T_H = 2, T_EXEC = 10, T_CLR = 30, T_PWRUP = 20;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        req_valid_i = 1'b0;
  logic        req_rs_i = 1'b0;
  logic [7:0]  req_data_i = 8'h00;
  logic        lcd_on_i = 1'b0;
  logic        req_ready_o, busy_o;
  logic [11:0] io_lcd_o;

  int checks = 0;
  int errors = 0;

  lcd_write_ctrl #(
    .T_AS_CYC(T_AS), .T_PW_CYC(T_PW), .T_H_CYC(T_H),
    .T_EXEC_CYC(T_EXEC), .T_CLR_CYC(T_CLR), .T_PWRUP_CYC(T_PWRUP)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
    .req_rs_i(req_rs_i), .req_data_i(req_data_i), .lcd_on_i(lcd_on_i),
    .busy_o(busy_o), .io_lcd_o(io_lcd_o)
  );

  // ---------------- clock ----------------
  always #5 clk_i = ~clk_i;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each write occupies a fixed window of edges after its accept edge e0.
  int          n, e0, ready_at, next_init_at;
  bit          have_txn, m_rs, m_on, m_prev_ready, m_acc, m_en, m_new_rs;
  logic [7:0]  m_db, m_new_db;
  logic [7:0]  init_q[$];
  logic [12:0] exp_q[$];

  function automatic int seq_len(input bit rs, input logic [7:0] d);
    return T_AS + T_PW + T_H + ((!rs && d >= 8'h01 && d <= 8'h03) ? T_CLR : T_EXEC);
  endfunction

  always @(posedge clk_i) begin
    if (!rst_ni) begin
      n = 0; e0 = 0; ready_at = 1; have_txn = 0;
      m_rs = 0; m_db = 8'h00; m_on = 0;
      init_q.delete();
`ifdef LCD_INIT_EN
      init_q = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
      next_init_at = T_PWRUP;
`endif
      exp_q.push_back(13'h0000);
    end else begin
      m_prev_ready = (init_q.size() == 0) && (n >= ready_at);
      m_acc = 0;
      m_new_rs = 0;
      m_new_db = 8'h00;
      if (init_q.size() != 0 && n + 1 == next_init_at) begin
        m_new_db = init_q.pop_front();
        m_acc = 1;
      end else if (m_prev_ready && req_valid_i) begin
        m_new_rs = req_rs_i;
        m_new_db = req_data_i;
        m_acc = 1;
      end
      n++;
      if (m_acc) begin
        e0 = n; have_txn = 1; m_rs = m_new_rs; m_db = m_new_db;
        ready_at = n + seq_len(m_new_rs, m_new_db);
        next_init_at = ready_at;
      end
      m_on = lcd_on_i;
      m_en = have_txn && (n >= e0 + T_AS) && (n < e0 + T_AS + T_PW);
      exp_q.push_back({(init_q.size() == 0) && (n >= ready_at), m_on, m_en, m_rs, 1'b0, m_db});
    end
  end

  // ---------------- scoreboard compare ----------------
  always @(posedge clk_i) begin
    logic [12:0] e;
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL cycle_model_empty at %0t", $time);
    end else begin
      e = exp_q.pop_front();
      chk("cycle_busy_ready_io", {18'h0, busy_o, req_ready_o, io_lcd_o}, {18'h0, ~e[12], e[12], e[11:0]});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_ready(input int bound);
    int k = 0;
    @(negedge clk_i);
    while (!req_ready_o && k < bound) begin
      @(negedge clk_i);
      k++;
    end
    if (!req_ready_o) begin
      checks++; errors++;
      $display("FAIL wait_ready_timeout actual=0 required=1 at %0t", $time);
    end
  endtask

  task automatic directed(input bit rs, input logic [7:0] d, input int lat);
    int k = 0, en_first = -1, en_cnt = 0;
    wait_ready(400);
    req_valid_i = 1; req_rs_i = rs; req_data_i = d;
    @(posedge clk_i);
    @(negedge clk_i);
    req_valid_i = 0;
    chk("accept_bus", {22'h0, io_lcd_o[9:0]}, {22'h0, rs, 1'b0, d});
    chk("accept_ready_drop", req_ready_o, 0);
    while (k < 200) begin
      if (io_lcd_o[10]) begin
        if (en_first < 0) en_first = k;
        en_cnt++;
      end
      if (req_ready_o) break;
      @(negedge clk_i);
      k++;
      req_data_i = 8'($urandom);
      req_rs_i = 1'($urandom_range(0, 1));
    end
    chk("ready_latency", k, lat);
    chk("en_start", en_first, T_AS);
    chk("en_width", en_cnt, T_PW);
  endtask

  task automatic back_to_back();
    int k = 0;
    int rise[$];
    logic [7:0] rise_db[$];
    bit prev_en = 0, sent2 = 0;
    wait_ready(400);
    req_valid_i = 1; req_rs_i = 1; req_data_i = 8'h41;
    @(posedge clk_i);
    while (k < 100 && rise.size() < 2) begin
      @(negedge clk_i);
      k++;
      if (io_lcd_o[10] && !prev_en) begin
        rise.push_back(k);
        rise_db.push_back(io_lcd_o[7:0]);
      end
      prev_en = io_lcd_o[10];
      if (!sent2 && req_ready_o) begin
        req_data_i = 8'h42;
        sent2 = 1;
      end else begin
        if (sent2) req_valid_i = 0;
        req_data_i = 8'($urandom);
      end
    end
    req_valid_i = 0;
    chk("b2b_pulse_count", rise.size(), 2);
    if (rise.size() == 2) begin
      chk("b2b_pulse_spacing", rise[1] - rise[0], T_AS + T_PW + T_H + T_EXEC + 1);
      chk("b2b_first_db", rise_db[0], 8'h41);
      chk("b2b_second_db", rise_db[1], 8'h42);
    end
  endtask

  task automatic reset_mid();
    int k = 0;
    wait_ready(400);
    req_valid_i = 1; req_rs_i = 1; req_data_i = 8'h55;
    @(negedge clk_i);
    req_valid_i = 0;
    while (!io_lcd_o[10] && k < 100) begin
      @(negedge clk_i);
      k++;
    end
    chk("rst_mid_en_seen", io_lcd_o[10], 1);
    #2 rst_ni = 0;
    #1;
    chk("rst_mid_io", io_lcd_o, 12'h000);
    chk("rst_mid_ready", req_ready_o, 0);
    chk("rst_mid_busy", busy_o, 1);
    repeat (2) @(negedge clk_i);
    rst_ni = 1;
  endtask

`ifdef LCD_INIT_EN
  task automatic init_check();
    int k = 0;
    logic [7:0] dbs[$];
    logic [7:0] exp_init[5] = '{8'h38, 8'h38, 8'h0C, 8'h01, 8'h06};
    bit prev_en = 0;
    while (k < 400) begin
      @(negedge clk_i);
      k++;
      if (io_lcd_o[10] && !prev_en) dbs.push_back(io_lcd_o[7:0]);
      prev_en = io_lcd_o[10];
      if (req_ready_o) break;
    end
    chk("init_ready_cycle", k, T_PWRUP + 4 * 18 + 38);
    chk("init_cmd_count", dbs.size(), 5);
    while (dbs.size() < 5) dbs.push_back(8'h00);
    for (int i = 0; i < 5; i++) chk("init_cmd_db", dbs[i], exp_init[i]);
  endtask
`endif

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(negedge clk_i);
    chk("reset_io", io_lcd_o, 12'h000);
    chk("reset_ready", req_ready_o, 0);
    chk("reset_busy", busy_o, 1);
    rst_ni = 1;
`ifdef LCD_INIT_EN
    init_check();
`else
    @(posedge clk_i);
    #1;
    chk("release_ready", req_ready_o, 1);
    chk("release_busy", busy_o, 0);
`endif
    lcd_on_i = 1;
    directed(1'b1, 8'h41, 18);
    directed(1'b0, 8'h01, 38);
    directed(1'b1, 8'h01, 18);
    directed(1'b0, 8'h04, 18);
    directed(1'b0, 8'h03, 38);
    directed(1'b0, 8'h00, 18);
    back_to_back();
    reset_mid();
    directed(1'b0, 8'h02, 38);

    repeat (700) begin
      @(negedge clk_i);
      req_valid_i = ($urandom_range(0, 3) != 0);
      req_rs_i = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: req_data_i = 8'($urandom_range(1, 3));
        1: req_data_i = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h04;
        default: req_data_i = 8'($urandom);
      endcase
      lcd_on_i = 1'($urandom_range(0, 1));
    end
    @(negedge clk_i);
    req_valid_i = 0;
    repeat (2) @(negedge clk_i);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
